// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the
// baud-count helper used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   localparam int UART_BIT_CNT_W  = $clog2(UART_DATA_BITS);

   // System clock cycles per serial bit (integer division).
   function automatic int uart_baud_cnt(input int system_clock, input int baud_rate);
      return system_clock / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Enable-gated bit-period counter; tick marks the last cycle of each bit.
// Held at zero while disabled so every frame starts on a fresh bit period.
module uart_baud_gen #(
   parameter int CNT_MAX = 5208
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int                CNT_W    = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      tick  = 1'b0;
      if (enable && !clear) begin
         if (cnt_q == CNT_LAST) begin
            tick = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with valid/ready byte intake and a
// one-cycle done pulse once the stop bit has been fully driven.
module uart_tx
   import uart_pkg::*;
#(
   parameter int baud_rate    = 9600,
   parameter int system_clock = 50000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       tx_done
);

   localparam int BAUD_CNT_MAX = uart_baud_cnt(system_clock, baud_rate);
   localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

   if (BAUD_CNT_MAX < 2) begin : g_bad_baud
      $error("uart_tx: system_clock/baud_rate must be at least 2");
   end
   if (UART_FRAME_BITS != UART_DATA_BITS + 2) begin : g_bad_frame
      $error("uart_tx: frame must be one start bit, data bits and one stop bit");
   end

   uart_state_e                state_q, state_d;
   logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
   logic [UART_BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                       tx_q, tx_d;
   logic                       tx_done_q, tx_done_d;
   logic                       accept;
   logic                       bit_tick;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid & in_ready;
   assign tx       = tx_q;
   assign tx_done  = tx_done_q;

   uart_baud_gen #(
      .CNT_MAX (BAUD_CNT_MAX)
   ) u_baud_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .enable    (state_q != ST_IDLE),
      .clear     (accept),
      .tick      (bit_tick)
   );

   // The line is registered from the next state so the start bit appears
   // in the very first cycle after acceptance.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_done_d = 1'b0;
      tx_d      = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d   = in_data;
               bit_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               state_d   = ST_IDLE;
               tx_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         tx_done_q <= tx_done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit: a frame-level model
// is compared every cycle, and directed scenarios pin literal timings/bits.
module tb_uart_tx;

   localparam int SYS_HZ    = 1000000;
   localparam int BAUD      = 100000;
   localparam int N         = SYS_HZ / BAUD;
   localparam int FRAME_CYC = 10 * N;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx;
   logic       tx_done;

   uart_tx #(
      .baud_rate    (BAUD),
      .system_clock (SYS_HZ)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx        (tx),
      .tx_done   (tx_done)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Frame model: m_k counts cycles since the acceptance cycle; the frame
   // occupies 1..FRAME_CYC and the done/ready cycle is FRAME_CYC+1.
   int         cyc       = 0;
   int         m_k       = 0;
   logic [9:0] m_frame   = '1;
   int         acc_cyc   = 0;
   int         acc_count = 0;
   bit         check_en  = 1'b0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_k <= 0;
      end else begin
         cyc <= cyc + 1;
         if ((m_k == 0 || m_k == FRAME_CYC + 1) && in_valid) begin
            m_k       <= 1;
            m_frame   <= {1'b1, in_data, 1'b0};
            acc_cyc   <= cyc;
            acc_count <= acc_count + 1;
         end else if (m_k == FRAME_CYC + 1) begin
            m_k <= 0;
         end else if (m_k != 0) begin
            m_k <= m_k + 1;
         end
      end
   end

   function automatic int expTx();
      if (m_k >= 1 && m_k <= FRAME_CYC) return int'(m_frame[(m_k - 1) / N]);
      return 1;
   endfunction

   function automatic int expReady();
      return (m_k >= 1 && m_k <= FRAME_CYC) ? 0 : 1;
   endfunction

   function automatic int expDone();
      return (m_k == FRAME_CYC + 1) ? 1 : 0;
   endfunction

   always @(negedge sys_clk) begin
      if (check_en) begin
         checkOutput("cycle tx", int'(tx), expTx());
         checkOutput("cycle in_ready", int'(in_ready), expReady());
         checkOutput("cycle tx_done", int'(tx_done), expDone());
      end
   end

   // Line monitor: recovers frames by mid-bit sampling and logs start,
   // done and ready-low run lengths from the DUT's own pins.
   int         rx_phase  = -1;
   logic [9:0] rx_bits   = '0;
   int         ready_run = 0;
   int         start_q[$];
   int         done_q[$];
   int         run_q[$];
   int         frame_q[$];

   always @(negedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_phase  <= -1;
         ready_run <= 0;
      end else begin
         if (rx_phase < 0) begin
            if (tx == 1'b0) begin
               rx_phase <= 0;
               start_q.push_back(cyc);
            end
         end else if (rx_phase % N == N / 2) begin
            if (rx_phase / N == 9) begin
               frame_q.push_back(int'({tx, rx_bits[8:0]}));
               rx_phase <= -1;
            end else begin
               rx_bits[rx_phase / N] <= tx;
               rx_phase <= rx_phase + 1;
            end
         end else begin
            rx_phase <= rx_phase + 1;
         end
         if (tx_done) done_q.push_back(cyc);
         if (!in_ready) begin
            ready_run <= ready_run + 1;
         end else if (ready_run > 0) begin
            run_q.push_back(ready_run);
            ready_run <= 0;
         end
      end
   end

   function automatic int popStart();
      if (start_q.size() == 0) return -1;
      return start_q.pop_front();
   endfunction

   function automatic int popDone();
      if (done_q.size() == 0) return -1;
      return done_q.pop_front();
   endfunction

   function automatic int popRun();
      if (run_q.size() == 0) return -1;
      return run_q.pop_front();
   endfunction

   function automatic int popFrame();
      if (frame_q.size() == 0) return -1;
      return frame_q.pop_front();
   endfunction

   task automatic clearQueues();
      start_q.delete();
      done_q.delete();
      run_q.delete();
      frame_q.delete();
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit hold, output int t_acc);
      int c0;
      c0       = acc_count;
      in_data  = data;
      in_valid = 1'b1;
      for (int i = 0; i < 500 && acc_count == c0; i++) begin
         @(posedge sys_clk);
         #1;
      end
      if (acc_count == c0) checkOutput("accept timeout", 0, 1);
      t_acc = acc_cyc;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic waitFrames(input int n);
      for (int i = 0; i < 3000 && (frame_q.size() < n || done_q.size() < n); i++) begin
         @(negedge sys_clk);
      end
      repeat (2) @(negedge sys_clk);
      checkOutput("frame count", frame_q.size(), n);
   endtask

   function automatic int frameByte(input int f);
      logic [9:0] fv;
      fv = f[9:0];
      return int'(fv[8:1]);
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         t1;
      int         t2;
      int         f;
      logic [9:0] a5_line;

      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check_en  = 1'b1;

      $display("[TB] reset / idle");
      repeat (200) @(negedge sys_clk);
      checkOutput("idle tx", int'(tx), 1);
      checkOutput("idle in_ready", int'(in_ready), 1);
      checkOutput("idle tx_done", int'(tx_done), 0);

      $display("[TB] single byte 0xA5");
      clearQueues();
      applyStimulus(8'hA5, 1'b0, t1);
      waitFrames(1);
      a5_line = 10'b11_0100_1010;
      f = popFrame();
      checkOutput("A5 line bits", f, int'(a5_line));
      checkOutput("A5 start latency", popStart() - t1, 1);
      checkOutput("A5 done latency", popDone() - t1, 101);
      checkOutput("A5 ready low run", popRun(), 100);

      $display("[TB] back-to-back 0x00 / 0xFF");
      clearQueues();
      applyStimulus(8'h00, 1'b1, t1);
      applyStimulus(8'hFF, 1'b0, t2);
      waitFrames(2);
      checkOutput("b2b byte 1", frameByte(popFrame()), 8'h00);
      checkOutput("b2b byte 2", frameByte(popFrame()), 8'hFF);
      checkOutput("b2b start 1", popStart() - t1, 1);
      checkOutput("b2b start 2", popStart() - t1, 102);
      checkOutput("b2b done 1", popDone() - t1, 101);
      checkOutput("b2b done 2", popDone() - t1, 202);
      checkOutput("b2b ready run 1", popRun(), 100);
      checkOutput("b2b ready run 2", popRun(), 100);

      $display("[TB] ignored input mid-frame");
      clearQueues();
      applyStimulus(8'hC3, 1'b0, t1);
      repeat (30) @(negedge sys_clk);
      in_data  = 8'h3C;
      in_valid = 1'b1;
      repeat (3) @(negedge sys_clk);
      in_valid = 1'b0;
      waitFrames(1);
      repeat (150) @(negedge sys_clk);
      checkOutput("ignored frame count", frame_q.size(), 1);
      checkOutput("ignored byte", frameByte(popFrame()), 8'hC3);

      $display("[TB] reset mid-frame");
      clearQueues();
      applyStimulus(8'h55, 1'b0, t1);
      repeat (44) @(posedge sys_clk);
      #2;
      checkOutput("0x55 bit3 before reset", int'(tx), 0);
      sys_rst_n = 1'b0;
      #1;
      checkOutput("reset tx", int'(tx), 1);
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset tx_done", int'(tx_done), 0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clearQueues();
      repeat (20) @(negedge sys_clk);
      applyStimulus(8'h81, 1'b0, t1);
      waitFrames(1);
      checkOutput("post-reset byte", frameByte(popFrame()), 8'h81);
      checkOutput("post-reset start", popStart() - t1, 1);
      checkOutput("post-reset done", popDone() - t1, 101);

      $display("[TB] data stability");
      clearQueues();
      applyStimulus(8'h0F, 1'b0, t1);
      for (int i = 0; i < 105; i++) begin
         @(negedge sys_clk);
         in_data  = in_data + 8'h35;
         in_valid = (i < 90);
      end
      in_valid = 1'b0;
      waitFrames(1);
      checkOutput("stability byte", frameByte(popFrame()), 8'h0F);
      checkOutput("stability done", popDone() - t1, 101);

      repeat (5) @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
